// File: rtl/compress_pkg.sv
// ---------------------------------------------------------------------------
// compress_pkg
//   Shared constants, types and helpers for the Kyber Compress_d stream unit.
//   Holds the modulus, frame size, datapath widths, the Barrett reciprocal
//   used to divide by Q, the legal-d check and the controller state enum.
// ---------------------------------------------------------------------------
package compress_pkg;

  localparam int unsigned Q      = 3329;  // Kyber modulus
  localparam int unsigned N      = 256;   // coefficients per frame
  localparam int unsigned CW     = 12;    // input coefficient width
  localparam int unsigned RW     = 11;    // result width (largest legal d)
  localparam int unsigned DW     = 4;     // width of the d control input
  localparam int unsigned HALF_Q = 1664;  // rounding offset, floor(Q/2)

  // Numerator x*2^d + HALF_Q stays below 2^23 for x < Q and d <= 11.
  localparam int unsigned NW  = 23;
  // Quotient never exceeds 2048, so 12 bits hold it.
  localparam int unsigned QEW = 12;

  // Barrett reciprocal: floor(2^24 / Q). For any numerator < 2^23 the
  // estimate (num * M) >> 24 is either the true quotient or one below it,
  // so a single conditional +1 completes the division.
  localparam int unsigned BARRETT_S = 24;
  localparam int unsigned BARRETT_M = 5039;
  localparam int unsigned BARRETT_W = NW + 13;  // M fits in 13 bits

  // Counters must represent 0..N inclusive.
  localparam int unsigned CNTW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Compression widths used by Kyber ciphertext encoding.
  function automatic logic is_legal_d(input logic [DW-1:0] dv);
    return (dv == DW'(1))  || (dv == DW'(4))  || (dv == DW'(5)) ||
           (dv == DW'(10)) || (dv == DW'(11));
  endfunction

endpackage

// File: rtl/compress_stream_if.sv
// ---------------------------------------------------------------------------
// compress_stream_if
//   Coefficient-in / result-out stream bundle for compress_stream.
//   slave  : the compress unit (consumes coefficients, produces results)
//   master : the environment feeding coefficients and draining results
//   Signals: in_valid/in_ready/coeff_in (input stream),
//            out_valid/out_ready/result/out_last (output stream).
// ---------------------------------------------------------------------------
interface compress_stream_if
  import compress_pkg::*;
();

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] coeff_in;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          out_last;

  modport master (
    output in_valid, coeff_in, out_ready,
    input  in_ready, out_valid, result, out_last
  );

  modport slave (
    input  in_valid, coeff_in, out_ready,
    output in_ready, out_valid, result, out_last
  );

endinterface

// File: rtl/compress_core.sv
// ---------------------------------------------------------------------------
// compress_core
//   Two-stage Compress_d datapath: result = floor((x*2^d + 1664) / Q) mod 2^d.
//   Stage 1: form the numerator and the Barrett quotient estimate.
//   Stage 2: one-step quotient correction, out-of-range zeroing, d-bit mask.
//   Each stage advances when the stage after it is empty or being consumed.
//
//   Optional build macro COMPRESS_MOD_Q_EN:
//     defined   - inputs x >= Q are reduced to x - Q before compression.
//     undefined - inputs x >= Q give result 0 and raise oor_hit on accept.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   d           compression width (held constant during a frame)
//   in_fire     coefficient accepted this cycle (loads stage 1)
//   in_x        coefficient value
//   s1_ready    stage 1 can take a new coefficient this cycle
//   oor_hit     accepted coefficient was >= Q (always 0 with the macro)
//   out_valid   stage 2 holds a result
//   out_ready   downstream consumes the stage 2 result
//   result      compressed value, zero above d bits
// ---------------------------------------------------------------------------
module compress_core
  import compress_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  input  logic          in_fire,
  input  logic [CW-1:0] in_x,
  output logic          s1_ready,
  output logic          oor_hit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] result
);

  logic           s1_valid;
  logic [NW-1:0]  s1_num;
  logic [QEW-1:0] s1_qe;
  logic           s1_zero;

  logic           s2_adv;
  logic [CW-1:0]  x_red;
  logic           x_oor;
  logic [NW-1:0]  num_d;
  logic [QEW-1:0] qe_d;
  logic [NW:0]    rem;
  logic [RW-1:0]  mask;
  logic [RW-1:0]  res_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_adv;

`ifdef COMPRESS_MOD_Q_EN
  assign x_oor = 1'b0;
  assign x_red = (in_x >= CW'(Q)) ? in_x - CW'(Q) : in_x;
`else
  assign x_oor = (in_x >= CW'(Q));
  assign x_red = in_x;
`endif

  assign oor_hit = in_fire && x_oor;

  // Stage 1 arithmetic: numerator and reciprocal-multiply quotient estimate.
  assign num_d = (NW'(x_red) << d) + NW'(HALF_Q);
  assign qe_d  = QEW'((BARRETT_W'(num_d) * BARRETT_W'(BARRETT_M)) >> BARRETT_S);

  // Stage 2 arithmetic: the estimate is at most one short, so the remainder
  // is in [0, 2Q) and a single compare fixes the quotient.
  assign rem   = (NW+1)'(s1_num) - (NW+1)'(s1_qe) * (NW+1)'(Q);
  assign mask  = ~({RW{1'b1}} << d);
  assign res_d = s1_zero ? '0
                         : (RW'(s1_qe + QEW'(rem >= (NW+1)'(Q))) & mask);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would let stage 2 see stage 1's
  // new contents in the same edge and collapse the pipeline.
  // NOTE: data registers are reset along with the valids because result
  // drives a port directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_num    <= '0;
      s1_qe     <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_num   <= num_d;
        s1_qe    <= qe_d;
        s1_zero  <= x_oor;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) result <= res_d;
      end
    end
  end

endmodule

// File: rtl/compress_stream.sv
// ---------------------------------------------------------------------------
// compress_stream
//   Streaming Kyber Compress_d unit between the polynomial datapath and the
//   ciphertext byte encoder. One start processes a frame of N coefficients
//   through a fixed 2-cycle pipeline (compress_core) at one coefficient per
//   cycle; this level owns the IDLE/RUN/DONE controller, the frame counters
//   and the stream handshakes.
//
//   Optional build macro COMPRESS_MOD_Q_EN (see compress_core): when defined
//   inputs >= Q are reduced mod Q and err_range never sets; when undefined
//   such inputs compress to 0 and set err_range until the next legal start.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       frame start pulse, honoured only in IDLE
//   d           compression width latched on start (1, 4, 5, 10, 11)
//   s           stream interface (slave): coefficients in, results out,
//               out_last marks the Nth result of the frame
//   busy        high while in RUN
//   done        one-cycle pulse after the last result is taken
//   err_bad_d   one-cycle pulse after a start with an illegal d
//   err_range   sticky out-of-range flag, cleared by a legal start
// ---------------------------------------------------------------------------
module compress_stream
  import compress_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   d,
  compress_stream_if.slave s,
  output logic            busy,
  output logic            done,
  output logic            err_bad_d,
  output logic            err_range
);

  state_t          state_q, state_d;
  logic [DW-1:0]   d_q;
  logic [CNTW-1:0] in_cnt_q;
  logic [CNTW-1:0] out_cnt_q;
  logic            err_bad_d_q;
  logic            err_range_q;

  logic            s1_ready;
  logic            oor_hit;
  logic            start_idle;
  logic            frame_start;
  logic            in_fire;
  logic            out_fire;
  logic            last_beat;

  assign start_idle  = (state_q == IDLE) && start;
  assign frame_start = start_idle && is_legal_d(d);

  // Input closes once the whole frame has been accepted.
  assign s.in_ready  = (state_q == RUN) && (in_cnt_q != CNTW'(N)) && s1_ready;
  assign in_fire     = s.in_valid && s.in_ready;
  assign out_fire    = s.out_valid && s.out_ready;
  assign last_beat   = (out_cnt_q == CNTW'(N - 1));
  assign s.out_last  = s.out_valid && last_beat;

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err_bad_d = err_bad_d_q;
  assign err_range = err_range_q;

  compress_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d_q),
    .in_fire   (in_fire),
    .in_x      (s.coeff_in),
    .s1_ready  (s1_ready),
    .oor_hit   (oor_hit),
    .out_valid (s.out_valid),
    .out_ready (s.out_ready),
    .result    (s.result)
  );

  // NOTE: next state is defaulted to the current state before the case so
  // every path assigns it and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = RUN;
      RUN:     if (out_fire && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      d_q         <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      err_bad_d_q <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_bad_d_q <= start_idle && !is_legal_d(d);

      if (frame_start) begin
        d_q         <= d;
        in_cnt_q    <= '0;
        out_cnt_q   <= '0;
        err_range_q <= 1'b0;
      end else begin
        if (in_fire) in_cnt_q <= in_cnt_q + CNTW'(1);
        if (out_fire && (state_q == RUN)) out_cnt_q <= out_cnt_q + CNTW'(1);
        if (oor_hit) err_range_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/compress_stream.md
Name: compress_stream

Overview:
- Streaming Kyber Compress_d unit: maps coefficients mod q=3329 to d-bit values, result = round(2^d·x/q) mod 2^d.
- It is the inverse direction of the existing decompress path.
- Sits between the NTT/polynomial datapath and the ciphertext byte-encoder.
- Processes one polynomial frame of N coefficients per start, with valid/ready on both sides and a fixed 2-stage arithmetic pipeline.

Parameters:
- N, 256, coefficients per frame.
- Q, 3329, modulus (package constant; no override).
- CW, 12, input coefficient width.
- RW, 11, result width (max d).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame start pulse; sampled only in IDLE.
- d  in  4  compression width, latched on start; legal values 1, 4, 5, 10, 11.
- in_valid  in  1  coefficient valid.
- in_ready  out  1  unit accepts coefficient.
- coeff_in  in  CW  coefficient x.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  RW  compressed value, zero-extended above d bits.
- out_last  out  1  qualifies the Nth result of the frame.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at frame end.
- err_bad_d  out  1  one-cycle pulse when start is seen with an illegal d.
- err_range  out  1  sticky flag, cleared on start (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, pipeline empty.
- Arithmetic: result = floor((x·2^d + 1664) / 3329) mod 2^d.
  - Must be exact for all x in [0,3328] and every legal d.
  - Numerator < 2^23; the divide by constant Q is done with Barrett/reciprocal multiply plus one correction step.
  - Bits above d are 0.
- Pipeline: stage 1 = multiply/add, stage 2 = quotient correction and mask.
  - Latency is 2 cycles from input handshake to out_valid with no stall.
  - Each stage advances when the next stage is empty or being consumed.
  - in_ready = RUN && (stage1 empty || stage1 advancing); no bubbles when out_ready is held high.
- Throughput: 1 coefficient/cycle.
- FSM states:
  - IDLE -> RUN on start with legal d (latch d, clear in_cnt/out_cnt, clear err_range).
  - start with illegal d: pulse err_bad_d, stay in IDLE.
  - RUN: in_cnt increments per input handshake; in_ready forced 0 once in_cnt == N.
  - RUN -> DONE on the output handshake with out_cnt == N-1 (out_last asserted on that beat).
  - DONE: done = 1 for one cycle -> IDLE.
- Boundaries:
  - start during RUN/DONE is ignored.
  - in_valid in IDLE is not accepted (in_ready = 0).
  - out_valid/result hold stable while out_ready = 0.
  - d = 10 and x = 3328 wraps to 0.
  - rst_n asserted mid-frame discards pipeline contents immediately and returns to IDLE.

Optional Feature:
- Macro: COMPRESS_MOD_Q_EN.
- Defined: inputs x ≥ Q are first reduced to x−Q (valid for x ≤ 4095), then compressed normally; err_range stays 0.
- Undefined: inputs x ≥ Q produce result 0 and set err_range, which stays set until the next legal start. The frame still completes normally.

Decomposition:
- Package compress_pkg holds:
  - Q, N, CW, RW;
  - Barrett constants (multiplier, shift);
  - legal-d check function;
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module compress_core: the 2-stage arithmetic pipeline with per-stage valid/enable. Top handles FSM, counters and handshake.

Test Plan:
- d=1, stream x=832, 833, 2497, 1664, out_ready=1 -> results 0, 1, 0, 1 at 2-cycle latency, back-to-back.
- d=10, x=1, 2, 3328 -> 0, 1, 0 (wrap); d=4, x=1000 -> 5; d=11, x=1665 -> 1024.
- Full frame of 256 coefficients with random out_ready stalls -> 256 results in order, no loss/duplication, out_last only on #256, done pulse one cycle later, busy drops.
- start with d=3 -> err_bad_d pulse, FSM stays IDLE, in_ready = 0.
- x=3400 at d=4: with COMPRESS_MOD_Q_EN -> result of x=71, i.e. 0; without -> result 0 and err_range set until next start.
- rst_n low for 1 cycle after 100 coefficients -> outputs 0 immediately; a new start then runs a clean full frame.
- Exhaustive sweep x=0..3328 for each legal d -> matches the golden formula.
